// File: rtl/stage_if_prefetch_if.sv
// Bus bundle between the prefetching IF stage, the instruction RAM port,
// the branch unit and the IF/ID latch.
// The master side is the fetch stage. The slave side is its environment.
interface stage_if_prefetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
);
   // downstream / branch unit -> fetch stage
   logic                  stall_id;
   logic                  br;
   logic [ADDR_WIDTH-1:0] br_addr;

   // instruction RAM port
   logic                  ram_read;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_ready;
   logic [INST_WIDTH-1:0] ram_data;

   // fetch stage -> IF/ID latch
   logic                  stall_if;
   logic                  valid_o;
   logic [ADDR_WIDTH-1:0] pc_o;
   logic [INST_WIDTH-1:0] inst_o;

   modport master (
      input  stall_id, br, br_addr, ram_ready, ram_data,
      output ram_read, ram_addr, stall_if, valid_o, pc_o, inst_o
   );

   modport slave (
      output stall_id, br, br_addr, ram_ready, ram_data,
      input  ram_read, ram_addr, stall_if, valid_o, pc_o, inst_o
   );
endinterface

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// Sequential words are fetched from the instruction RAM into a FIFO. The head
// entry is presented to ID. A redirect flushes the queue. A redirect also
// squashes the RAM response that is in flight, because a RAM request cannot
// be withdrawn once issued.
module stage_if_prefetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter int                    PC_STEP    = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input logic                 clk,
   input logic                 reset,
   stage_if_prefetch_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);

   // IDLE: no request outstanding. REQ: the request at ram_addr is live.
   // DISCARD: the request at ram_addr is stale and its response is dropped.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t                state, state_next;
   logic                  ram_read_q, ram_read_next;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_next;
   logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;

   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [CNT_W-1:0]      count, count_next;
   logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
   logic [INST_WIDTH-1:0] q_inst [DEPTH];

   logic                  head_valid;
   logic                  push;
   logic                  pop;

   // Queue bookkeeping. A redirect beats both push and pop in the same cycle.
   always_comb begin
      head_valid = (count != '0);
      pop        = head_valid && !bus.stall_id && !bus.br;
      push       = (state == REQ) && bus.ram_ready && !bus.br;
      count_next = count;
      if (bus.br) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (!push && pop) begin
         count_next = count - CNT_W'(1);
      end
   end

   // Fetch FSM next state and next values of the registered RAM request.
   // NOTE: every output gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next    = state;
      ram_read_next = ram_read_q;
      ram_addr_next = ram_addr_q;
      fetch_pc_next = fetch_pc;
      case (state)
         IDLE: begin
            if (bus.br) begin
               state_next    = REQ;
               ram_read_next = 1'b1;
               ram_addr_next = bus.br_addr;
               fetch_pc_next = bus.br_addr;
            end else if (count < CNT_FULL) begin
               state_next    = REQ;
               ram_read_next = 1'b1;
               ram_addr_next = fetch_pc;
            end
         end
         REQ: begin
            if (bus.br) begin
               fetch_pc_next = bus.br_addr;
               if (bus.ram_ready) begin
                  // Response dropped. Re-issue at the target right away.
                  ram_addr_next = bus.br_addr;
               end else begin
                  // Request cannot be withdrawn. Wait for it and drop it.
                  state_next = DISCARD;
               end
            end else if (bus.ram_ready) begin
               fetch_pc_next = fetch_pc + STEP;
               // count_next already includes this push and any pop in the
               // same cycle. A new request therefore always has a free slot.
               if (count_next < CNT_FULL) begin
                  ram_addr_next = fetch_pc + STEP;
               end else begin
                  state_next    = IDLE;
                  ram_read_next = 1'b0;
               end
            end
         end
         DISCARD: begin
            if (bus.br) begin
               fetch_pc_next = bus.br_addr;
            end
            if (bus.ram_ready) begin
               state_next    = REQ;
               ram_addr_next = bus.br ? bus.br_addr : fetch_pc;
            end
         end
         default: begin
            state_next    = IDLE;
            ram_read_next = 1'b0;
         end
      endcase
   end

   // FSM state, RAM request and fetch address registers.
   // NOTE: clocked state uses non-blocking assignments, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ram_read_q <= 1'b0;
         ram_addr_q <= '0;
         fetch_pc   <= RESET_PC;
      end else begin
         state      <= state_next;
         ram_read_q <= ram_read_next;
         ram_addr_q <= ram_addr_next;
         fetch_pc   <= fetch_pc_next;
      end
   end

   // Queue pointers and occupancy. A flush snaps the read pointer onto the write pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_next;
         if (bus.br) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
         end
      end
   end

   // Queue storage. The PC stored with each word is the address that fetched it.
   // NOTE: storage is not reset; an entry is only observable while count covers it, and count is reset.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]   <= ram_addr_q;
         q_inst[wr_ptr] <= bus.ram_data;
      end
   end

   assign bus.ram_read = ram_read_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.valid_o  = head_valid;
   assign bus.stall_if = !head_valid;
   assign bus.pc_o     = head_valid ? q_pc[rd_ptr]   : '0;
   assign bus.inst_o   = head_valid ? q_inst[rd_ptr] : '0;
endmodule
